// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage -- ID/EX pipeline register with load-use hazard detection.
//
// Holds the decoded instruction on its way from ID to EX and feeds the
// forwarding unit. Each clock edge does exactly one action, highest priority
// first:
//   Flush      : squash. Control fields clear, data/register fields load ID.
//   Stall_Ext  : memory-side freeze. Every EX_* field holds its value.
//   Hazard     : load-use stall. A bubble is loaded, PC and IF/ID hold, and
//                Bubble_Count increments. The count saturates at 16'hFFFF.
//   otherwise  : normal advance. Every EX_* field loads its ID_* input.
//
// Optional feature macro: LOAD_USE_STALL_EN
//   defined   : the load-use hazard detector and Bubble_Count are built.
//   undefined : Hazard is constant 0 and Bubble_Count is tied to 0. The
//               compiler is then responsible for load-use ordering.
//
// Ports
//   clk, reset_n                 clock; asynchronous active-low reset
//   ID_RS/RT/RD [1:0]            decoded register numbers
//   ID_Use_RS, ID_Use_RT         ID instruction really reads RS / RT
//   ID_Valid, ID_Reg_Write,
//   ID_Mem_Read, ID_Mem_Write    decoded validity and control
//   ID_ALU_Op [3:0]              ALU operation
//   ID_RS_Data/RT_Data/Imm/PC    16-bit operands, immediate and PC
//   Flush                        branch/jump squash from EX
//   Stall_Ext                    memory-side pipeline freeze
//   EX_* outputs                 registered ID/EX contents
//   PC_Write, IF_ID_Write        combinational enables for PC and IF/ID
//   Bubble_Count [15:0]          number of load-use bubbles inserted
// ---------------------------------------------------------------------------
module id_ex_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  ID_RS,
  input  logic [1:0]  ID_RT,
  input  logic [1:0]  ID_RD,
  input  logic        ID_Use_RS,
  input  logic        ID_Use_RT,
  input  logic        ID_Valid,
  input  logic        ID_Reg_Write,
  input  logic        ID_Mem_Read,
  input  logic        ID_Mem_Write,
  input  logic [3:0]  ID_ALU_Op,
  input  logic [15:0] ID_RS_Data,
  input  logic [15:0] ID_RT_Data,
  input  logic [15:0] ID_Imm,
  input  logic [15:0] ID_PC,
  input  logic        Flush,
  input  logic        Stall_Ext,
  output logic [1:0]  EX_RS,
  output logic [1:0]  EX_RT,
  output logic [1:0]  EX_RD,
  output logic        EX_Valid,
  output logic        EX_Reg_Write,
  output logic        EX_Mem_Read,
  output logic        EX_Mem_Write,
  output logic [3:0]  EX_ALU_Op,
  output logic [15:0] EX_RS_Data,
  output logic [15:0] EX_RT_Data,
  output logic [15:0] EX_Imm,
  output logic [15:0] EX_PC,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic [15:0] Bubble_Count
);

  logic hazard_s;     // load-use hazard against the current EX contents
  logic hold_s;       // keep every EX_* field as it is
  logic bubble_s;     // load a bubble: control fields cleared
  logic count_s;      // this edge inserts a counted load-use bubble
  logic enable_s;     // shared value of PC_Write and IF_ID_Write

`ifdef LOAD_USE_STALL_EN
  logic [15:0] bubble_count_r;

  // Load-use detector: the instruction in EX is a valid load whose
  // destination the ID instruction actually reads.
  always_comb begin
    hazard_s = 1'b0;
    if (EX_Valid && EX_Mem_Read && ID_Valid) begin
      hazard_s = (ID_Use_RS && (EX_RD == ID_RS)) ||
                 (ID_Use_RT && (EX_RD == ID_RT));
    end else begin
      hazard_s = 1'b0;
    end
  end
`else
  logic unused_s;

  assign hazard_s = 1'b0;
  // These inputs only matter to the hazard detector.
  assign unused_s = ^{ID_Use_RS, ID_Use_RT, count_s};
`endif

  // Per-edge action decode. Flush beats Stall_Ext, which beats Hazard.
  // While reset is asserted the front end is released so that reset can
  // abort a stall.
  always_comb begin
    hold_s   = 1'b0;
    bubble_s = 1'b0;
    count_s  = 1'b0;
    enable_s = 1'b1;
    if (!reset_n) begin
      enable_s = 1'b1;
    end else if (Flush) begin
      bubble_s = 1'b1;
    end else if (Stall_Ext) begin
      hold_s   = 1'b1;
      enable_s = 1'b0;
    end else if (hazard_s) begin
      bubble_s = 1'b1;
      count_s  = 1'b1;
      enable_s = 1'b0;
    end else begin
      enable_s = 1'b1;
    end
  end

  assign PC_Write    = enable_s;
  assign IF_ID_Write = enable_s;

  // ID/EX register. Data and register fields always follow ID unless held.
  // Reg_Write is gated with Valid so an invalid slot can never write back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      EX_RS        <= 2'b00;
      EX_RT        <= 2'b00;
      EX_RD        <= 2'b00;
      EX_Valid     <= 1'b0;
      EX_Reg_Write <= 1'b0;
      EX_Mem_Read  <= 1'b0;
      EX_Mem_Write <= 1'b0;
      EX_ALU_Op    <= 4'h0;
      EX_RS_Data   <= 16'h0000;
      EX_RT_Data   <= 16'h0000;
      EX_Imm       <= 16'h0000;
      EX_PC        <= 16'h0000;
    end else if (!hold_s) begin
      EX_RS      <= ID_RS;
      EX_RT      <= ID_RT;
      EX_RD      <= ID_RD;
      EX_RS_Data <= ID_RS_Data;
      EX_RT_Data <= ID_RT_Data;
      EX_Imm     <= ID_Imm;
      EX_PC      <= ID_PC;
      if (bubble_s) begin
        EX_Valid     <= 1'b0;
        EX_Reg_Write <= 1'b0;
        EX_Mem_Read  <= 1'b0;
        EX_Mem_Write <= 1'b0;
        EX_ALU_Op    <= 4'h0;
      end else begin
        EX_Valid     <= ID_Valid;
        EX_Reg_Write <= ID_Reg_Write & ID_Valid;
        EX_Mem_Read  <= ID_Mem_Read;
        EX_Mem_Write <= ID_Mem_Write;
        EX_ALU_Op    <= ID_ALU_Op;
      end
    end
  end

`ifdef LOAD_USE_STALL_EN
  // Saturating load-use bubble counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bubble_count_r <= 16'h0000;
    end else if (count_s && (bubble_count_r != 16'hFFFF)) begin
      bubble_count_r <= bubble_count_r + 16'h0001;
    end
  end

  assign Bubble_Count = bubble_count_r;
`else
  assign Bubble_Count = 16'h0000;
`endif

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 ID_RS, ID_RT, ID_RD  in  2 each  decoded source/source/destination register numbers.
REQ-004 ID_Use_RS, ID_Use_RT  in  1 each  ID instruction actually reads RS/RT.
REQ-005 ID_Valid, ID_Reg_Write, ID_Mem_Read, ID_Mem_Write  in  1 each  decoded validity and control.
REQ-006 ID_ALU_Op  in  4  ALU operation; ID_RS_Data, ID_RT_Data, ID_Imm, ID_PC  in  16 each.
REQ-007 Flush  in  1  branch/jump squash from EX; Stall_Ext  in  1  memory-side pipeline freeze.
REQ-008 EX_RS, EX_RT, EX_RD  out  2 each; EX_Valid, EX_Reg_Write, EX_Mem_Read, EX_Mem_Write  out  1 each; EX_ALU_Op  out  4; EX_RS_Data, EX_RT_Data, EX_Imm, EX_PC  out  16 each: registered ID/EX contents feeding EX and the forwarding unit.
REQ-009 PC_Write, IF_ID_Write  out  1 each  combinational enables for PC and IF/ID register.
REQ-010 Bubble_Count  out  16  number of load-use bubbles inserted.

Function
REQ-011 Hazard = EX_Valid & EX_Mem_Read & ID_Valid & ((ID_Use_RS & EX_RD==ID_RS) | (ID_Use_RT & EX_RD==ID_RT)), evaluated combinationally on current EX_* register outputs.
REQ-012 Priority per edge: Flush > Stall_Ext > Hazard > normal advance.
REQ-013 Normal: all EX_* outputs load the corresponding ID_* inputs on the rising edge; latency one cycle.
REQ-014 Flush: EX_Valid, EX_Reg_Write, EX_Mem_Read, EX_Mem_Write and EX_ALU_Op load 0; data/register fields load ID values; PC_Write=1, IF_ID_Write=1; no bubble counted.
REQ-015 Stall_Ext (no Flush): all EX_* hold; PC_Write=0, IF_ID_Write=0; Hazard ignored and not counted.
REQ-016 Hazard (no Flush, no Stall_Ext): bubble loaded as in REQ-014; PC_Write=0, IF_ID_Write=0; Bubble_Count increments by 1.
REQ-017 A bubble has EX_Valid=0, so the same ID instruction raises no hazard in the following cycle; load-use stall is exactly one cycle.
REQ-018 Otherwise PC_Write=1, IF_ID_Write=1.
REQ-019 Bubble_Count saturates at 16'hFFFF; no wrap.
REQ-020 EX_Reg_Write=0 whenever EX_Valid=0, at all times.

Reset
REQ-021 reset_n low asynchronously clears all EX_* outputs and Bubble_Count to 0; EX_Valid=0 makes the EX stage a bubble.
REQ-022 While reset_n is low, PC_Write=1 and IF_ID_Write=1; reset asserted mid-stall aborts the stall, and the first edge after release performs a normal advance.

Configuration
REQ-023 Macro LOAD_USE_STALL_EN: when defined, REQ-011/016/019 apply; when undefined, Hazard is constant 0, no bubbles are inserted, Bubble_Count is tied to 0, and load-use ordering is the compiler's responsibility.

Verification
REQ-024 Reset: reset_n=0 mid-cycle -> all EX_* and Bubble_Count 0 immediately; PC_Write=1.
REQ-025 Load-use: EX holds LW RD=2 (Valid=1, Mem_Read=1), ID ADD RS=2 Use_RS=1 -> PC_Write=0 that cycle; next edge EX_Valid=0, Bubble_Count=1; following edge EX_RS=2, EX_Valid=1.
REQ-026 No false hazard: EX LW RD=2, ID uses RS=1, RT=3 -> PC_Write=1, no bubble; same with Use_RT=0 and ID_RT=2 -> no bubble.
REQ-027 Simultaneous: Hazard and Flush both asserted -> bubble loaded, PC_Write=1, Bubble_Count unchanged; Hazard and Stall_Ext -> EX_* hold, count unchanged.
REQ-028 Saturation: preload count via 65535 hazards -> Bubble_Count=16'hFFFF; one more hazard -> stays 16'hFFFF.
REQ-029 Build without LOAD_USE_STALL_EN: REQ-025 stimulus -> PC_Write=1, EX_Valid=1 next edge, Bubble_Count=0.
